// File: rtl/mem_bus_unit.sv
// ============================================================================
// mem_bus_unit : single-access memory bus unit (strobe/ack handshake)
// Optional abort-on-timeout enabled by defining BUS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_unit #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mar,
  input  logic [WIDTH-1:0] writedata,
  input  logic             rdreq,
  input  logic             wrreq,
  output logic [WIDTH-1:0] memdata,
  output logic             memready,
  output logic             busy,
  output logic [WIDTH-1:0] bus_adr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic             bus_rd,
  output logic             bus_wr,
  input  logic [WIDTH-1:0] bus_rdata,
  input  logic             bus_ack,
  output logic             buserr
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bus_adr_q, bus_adr_d;
  logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [WIDTH-1:0] memdata_q, memdata_d;
  logic             bus_rd_q, bus_rd_d;
  logic             bus_wr_q, bus_wr_d;
  logic             w_abort;
  logic             w_finish;

`ifdef BUS_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT + 1);

  logic [c_CW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Ack on the final counted cycle takes priority over the abort.
  assign w_abort = (state_q == c_ACCESS) && !bus_ack && (cnt_q == c_CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == c_ACCESS && !bus_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = w_abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign buserr = err_q;
`else
  localparam int c_unused_timeout = TIMEOUT;

  assign w_abort = 1'b0;
  assign buserr  = 1'b0;
`endif

  assign w_finish = (state_q == c_ACCESS) && (bus_ack || w_abort);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:   if (rdreq || wrreq) state_d = c_ACCESS;
      c_ACCESS: if (w_finish) state_d = c_DONE;
      c_DONE:   state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  // Strobes are registered: set on acceptance, cleared on the completing edge.
  always_comb begin
    bus_adr_d   = bus_adr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;
    memdata_d   = memdata_q;
    if (state_q == c_IDLE && (rdreq || wrreq)) begin
      bus_adr_d   = mar;
      bus_wdata_d = writedata;
      bus_wr_d    = wrreq;
      bus_rd_d    = rdreq & ~wrreq;
    end
    if (w_finish) begin
      bus_rd_d = 1'b0;
      bus_wr_d = 1'b0;
      if (bus_rd_q) begin
        memdata_d = bus_ack ? bus_rdata : '1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_adr_q   <= '0;
      bus_wdata_q <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      memdata_q   <= '0;
    end else begin
      bus_adr_q   <= bus_adr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      memdata_q   <= memdata_d;
    end
  end

  always_comb begin
    memready  = (state_q == c_DONE);
    busy      = (state_q != c_IDLE);
    bus_adr   = bus_adr_q;
    bus_wdata = bus_wdata_q;
    bus_rd    = bus_rd_q;
    bus_wr    = bus_wr_q;
    memdata   = memdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_unit.sv
// ============================================================================
// tb_mem_bus_unit : randomized self-checking bench for mem_bus_unit
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_unit;

  localparam int W  = 8;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] mar = '0;
  logic [W-1:0] writedata = '0;
  logic         rdreq = 1'b0;
  logic         wrreq = 1'b0;
  logic [W-1:0] bus_rdata = '0;
  logic         bus_ack = 1'b0;
  logic [W-1:0] memdata;
  logic         memready;
  logic         busy;
  logic [W-1:0] bus_adr;
  logic [W-1:0] bus_wdata;
  logic         bus_rd;
  logic         bus_wr;
  logic         buserr;

  mem_bus_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .mar       (mar),
    .writedata (writedata),
    .rdreq     (rdreq),
    .wrreq     (wrreq),
    .memdata   (memdata),
    .memready  (memready),
    .busy      (busy),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .buserr    (buserr)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] m_mem = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},     busy,     0);
    check({tag, ".memready"}, memready, 0);
    check({tag, ".bus_rd"},   bus_rd,   0);
    check({tag, ".bus_wr"},   bus_wr,   0);
    check({tag, ".buserr"},   buserr,   0);
    check({tag, ".memdata"},  memdata,  m_mem);
  endtask

  // One access: request, (waits) unacknowledged ACCESS cycles, then ack.
  task automatic do_txn(input logic rd, input logic wr, input logic [W-1:0] adr,
                        input logic [W-1:0] wd, input int waits, input logic [W-1:0] rdata);
    logic er;
    logic ew;
    er = rd & ~wr;
    ew = wr;
    mar = adr; writedata = wd; rdreq = rd; wrreq = wr;
    bus_ack = 1'b0; bus_rdata = W'($urandom);
    tick();
    for (int k = 0; k <= waits; k++) begin
      check("acc.bus_rd",    bus_rd,    er);
      check("acc.bus_wr",    bus_wr,    ew);
      check("acc.bus_adr",   bus_adr,   adr);
      check("acc.bus_wdata", bus_wdata, wd);
      check("acc.busy",      busy,      1);
      check("acc.memready",  memready,  0);
      check("acc.memdata",   memdata,   m_mem);
      mar = W'($urandom); writedata = W'($urandom);
      rdreq = 1'($urandom); wrreq = 1'($urandom);
      bus_ack   = (k == waits);
      bus_rdata = (k == waits) ? rdata : W'($urandom);
      tick();
    end
    if (er) m_mem = rdata;
    check("done.memready", memready, 1);
    check("done.busy",     busy,     1);
    check("done.bus_rd",   bus_rd,   0);
    check("done.bus_wr",   bus_wr,   0);
    check("done.buserr",   buserr,   0);
    check("done.memdata",  memdata,  m_mem);
    rdreq = 1'($urandom); wrreq = 1'($urandom); bus_ack = 1'($urandom);
    tick();
    check_idle("post");
    rdreq = 1'b0; wrreq = 1'b0;
    bus_ack = 1'($urandom); bus_rdata = W'($urandom);
    tick();
    check_idle("stray");
    bus_ack = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, d, r;
    int kind;

    tick();
    check("rst.memdata",   memdata,   0);
    check("rst.bus_adr",   bus_adr,   0);
    check("rst.bus_wdata", bus_wdata, 0);
    check_idle("rst");
    reset = 1'b0;
    tick();
    check_idle("rst.rel");

    do_txn(1'b1, 1'b0, 8'h2C, 8'h00, 0, 8'hA5);
    check("rd.memdata", memdata, 8'hA5);
    do_txn(1'b0, 1'b1, 8'h68, 8'h3C, 3, 8'h99);
    check("wr.memdata", memdata, 8'hA5);
    do_txn(1'b1, 1'b1, 8'h12, 8'h34, 1, 8'h55);
    do_txn(1'b0, 1'b1, 8'h70, 8'h0F, 14, 8'h00);
    do_txn(1'b1, 1'b0, 8'h71, 8'h00, 14, 8'h5A);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = W'($urandom); d = W'($urandom); r = W'($urandom);
      do_txn(kind != 1, kind != 0, a, d, $urandom_range(0, 5), r);
    end

    // Asynchronous reset in the middle of a read.
    mar = 8'h4D; rdreq = 1'b1; wrreq = 1'b0; bus_ack = 1'b0;
    tick();
    rdreq = 1'b0;
    check("mid.bus_rd", bus_rd, 1);
    #2 reset = 1'b1;
    #1;
    m_mem = '0;
    check("arst.bus_adr",   bus_adr,   0);
    check("arst.bus_wdata", bus_wdata, 0);
    check_idle("arst");
    @(posedge clk);
    #1 reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 8'h77;
    tick();
    bus_ack = 1'b0;
    check_idle("arst.ack");

`ifdef BUS_TIMEOUT_EN
    mar = 8'h11; rdreq = 1'b1; wrreq = 1'b0; bus_ack = 1'b0;
    tick();
    rdreq = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("to.bus_rd",   bus_rd,   1);
      check("to.memready", memready, 0);
      check("to.buserr",   buserr,   0);
      tick();
    end
    m_mem = 8'hFF;
    check("to.done.memready", memready, 1);
    check("to.done.buserr",   buserr,   1);
    check("to.done.bus_rd",   bus_rd,   0);
    check("to.done.memdata",  memdata,  8'hFF);
    tick();
    check_idle("to.post");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
